// File: rtl/alu_pkg.sv
// Shared ALU definitions: HI/LO opcodes and the multiplier state encoding.
// Imported by the decoder and by seq_multiplier.
package alu_pkg;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for the HI/LO unit (MULT/MULTU).
// Signed operands are reduced to magnitudes; the sign is applied in FIX.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

    mul_state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH:0]   acc_q;
    logic               neg_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               load_en, step_en, fix_en;
    logic               last_iter;
    logic [WIDTH-1:0]   a_mag, b_mag, addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   acc_d;
    logic [2*WIDTH-1:0] prod, result;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: WIDTH steps in CALC, then one FIX cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_iter) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        load_en = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        unique case (state_q)
            IDLE:    load_en = start;
            CALC:    step_en = 1'b1;
            FIX:     fix_en  = 1'b1;
            default: ;
        endcase
    end

    // Operand magnitudes, one add-shift step, and the final sign fix.
    always_comb begin
        a_mag  = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
        b_mag  = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
        addend = acc_q[0] ? mcand_q : '0;
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_d  = {1'b0, sum, acc_q[WIDTH-1:1]};
        prod   = acc_q[2*WIDTH-1:0];
        result = neg_q ? (~prod + ONE2) : prod;
    end

    // Datapath registers; hi/lo only move on FIX so old HI/LO stay readable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fix_en;
            if (load_en) begin
                mcand_q <= a_mag;
                acc_q   <= {{(WIDTH+1){1'b0}}, b_mag};
                neg_q   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                cnt_q   <= '0;
            end else if (step_en) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (fix_en) begin
                hi_q <= result[2*WIDTH-1:WIDTH];
                lo_q <= result[WIDTH-1:0];
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
